divisor_driver: RTL and testbench

- Initiator side of the divider handshake (START/NUMERADOR/DENOMINADOR out, COC/RES/DONE in), replacing the testbench stimulus driver with synthesizable RTL.
- Accepts operand pairs on a valid/ready input, issues one division at a time, and captures the quotient/remainder.
- Presents results on a valid/ready output.
- Handles divide-by-zero locally and guards against a hung divider with a timeout.

---
 rtl/divisor_driver.sv | 145 ++++++++++++++
 tb/tb_divisor_driver.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_driver.sv
// rtl/divisor_driver.sv - initiator side of the START/NUMERADOR/DENOMINADOR divider handshake
//
// Accepts one operand pair at a time on a valid/ready input. Pairs with a
// non-zero denominator go to the external divider. A zero denominator is
// answered locally. The driver gives up on a silent divider after TIMEOUT
// cycles. The quotient, remainder and error code are held on a valid/ready
// output until the consumer takes them.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     operand handshake, in_num / in_den operands
//   div_start             one-cycle start pulse to the divider
//   div_num/div_den       registered operands, stable while waiting
//   div_coc/div_res       divider quotient / remainder, valid with div_done
//   out_valid/out_ready   result handshake, out_coc / out_res / out_err
//   out_err               00 ok, 01 divide-by-zero, 10 timeout
//   busy                  high whenever the FSM is not idle
//   ops_cnt               results delivered since reset, wrapping

module divisor_driver #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_num,
  input  logic [SIZE-1:0]  in_den,
  output logic             div_start,
  output logic [SIZE-1:0]  div_num,
  output logic [SIZE-1:0]  div_den,
  input  logic [SIZE-1:0]  div_coc,
  input  logic [SIZE-1:0]  div_res,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_coc,
  output logic [SIZE-1:0]  out_res,
  output logic [1:0]       out_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      in_ready  <= 1'b0;
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      out_valid <= 1'b0;
      out_coc   <= '0;
      out_res   <= '0;
      out_err   <= ERR_OK;
      busy      <= 1'b0;
      ops_cnt   <= '0;
    end else begin
      // The start pulse only ever lives for the ISSUE cycle.
      div_start <= 1'b0;

      case (state)
        IDLE: begin
          // in_ready comes up one cycle after reset and then stays up until a pair is taken.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_den != '0) begin
              div_num   <= in_num;
              div_den   <= in_den;
              div_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              // Answer a zero denominator locally. The divider never sees it.
              out_coc   <= '1;
              out_res   <= in_num;
              out_err   <= ERR_DIV0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end

        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // div_done is checked before expiry, so a result that arrives on the last cycle is kept.
          if (div_done) begin
            out_coc   <= div_coc;
            out_res   <= div_res;
            out_err   <= ERR_OK;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (tcnt == T_LAST) begin
            out_coc   <= '0;
            out_res   <= '0;
            out_err   <= ERR_TOUT;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            ops_cnt   <= ops_cnt + 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_driver.sv
// tb/tb_divisor_driver.sv - randomized self-checking bench for divisor_driver

module tb_divisor_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_num;
  logic [7:0]  in_den;
  logic        div_start;
  logic [7:0]  div_num;
  logic [7:0]  div_den;
  logic [7:0]  div_coc;
  logic [7:0]  div_res;
  logic        div_done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_coc;
  logic [7:0]  out_res;
  logic [1:0]  out_err;
  logic        busy;
  logic [15:0] ops_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ops = 0;

  divisor_driver #(.SIZE(8), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coc(out_coc), .out_res(out_res), .out_err(out_err),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  // Divider model. It sees div_start, waits dm_lat cycles and then raises div_done with num/den.
  // Between results the quotient and remainder lines carry junk.
  int         dm_lat   = 4;
  bit         dm_never = 1'b0;
  int         dm_cnt   = 0;
  logic [7:0] dm_num, dm_den;

  always @(negedge clk) begin
    div_done = 1'b0;
    div_coc  = 8'($urandom);
    div_res  = 8'($urandom);
    if (div_start) begin
      dm_cnt = dm_lat;
      dm_num = div_num;
      dm_den = div_den;
    end else if (dm_cnt > 0) begin
      dm_cnt--;
      if (dm_cnt == 0 && !dm_never && dm_den != 0) begin
        div_done = 1'b1;
        div_coc  = dm_num / dm_den;
        div_res  = dm_num % dm_den;
      end
    end
  end

  // Present one pair for one cycle once in_ready is up. The task returns at the negedge of cycle 1.
  task automatic issue(input logic [7:0] num, input logic [7:0] den);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_num   = num;
    in_den   = den;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts the cycles from the current one until out_valid is seen (0 means it is high now).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL wait_out: out_valid=%0b required 1 within 300 cycles", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, div_start, div_num, div_den, out_valid, out_coc, out_res, out_err, busy, ops_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: in_ready=%0b div_start=%0b out_valid=%0b busy=%0b ops=%0d required all 0",
               in_ready, div_start, out_valid, busy, ops_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
    end
    exp_ops = 0;
  endtask

  task automatic test_basic();
    int n;
    dm_lat = 4;
    issue(8'd100, 8'd7);
    n_tests++;
    if (div_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || div_num !== 8'd100 || div_den !== 8'd7) begin
      n_fail++;
      $display("FAIL basic_start: start=%0b rdy=%0b busy=%0b num=%0d den=%0d required 1 0 1 100 7",
               div_start, in_ready, busy, div_num, div_den);
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (div_start !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_wait c%0d: start=%0b out_valid=%0b required 0 0", c, div_start, out_valid);
      end
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_coc !== 8'd14 || out_res !== 8'd2 || out_err !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_result: v=%0b coc=%0d res=%0d err=%0d required 1 14 2 0",
               out_valid, out_coc, out_res, out_err);
    end
    handshake();
    n_tests++;
    if (out_valid !== 1'b0 || ops_cnt !== 16'd1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after: v=%0b ops=%0d rdy=%0b required 0 1 1", out_valid, ops_cnt, in_ready);
    end
  endtask

  task automatic test_div_zero();
    issue(8'd200, 8'd0);
    n_tests++;
    if (out_valid !== 1'b1 || out_coc !== 8'd255 || out_res !== 8'd200 || out_err !== 2'b01 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL div0: v=%0b coc=%0d res=%0d err=%0d start=%0b required 1 255 200 1 0",
               out_valid, out_coc, out_res, out_err, div_start);
    end
    handshake();
    n_tests++;
    if (ops_cnt !== 16'(exp_ops) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL div0_after: ops=%0d rdy=%0b required %0d 1", ops_cnt, in_ready, exp_ops);
    end
  endtask

  task automatic test_timeout();
    int n;
    // No answer at all. WAIT lasts 64 cycles, so out_valid shows up at cycle 66.
    dm_never = 1'b1;
    issue(8'd1, 8'd1);
    wait_out(n);
    n_tests++;
    if (n !== 65 || out_err !== 2'b10 || out_coc !== 8'd0 || out_res !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout: cyc=%0d err=%0d coc=%0d res=%0d required 65 2 0 0", n + 1, out_err, out_coc, out_res);
    end
    handshake();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: rdy=%0b v=%0b required 1 0", in_ready, out_valid);
    end
    dm_never = 1'b0;
    // The answer lands on the last cycle before expiry and must win.
    dm_lat = 64;
    issue(8'd13, 8'd5);
    wait_out(n);
    n_tests++;
    if (n !== 65 || out_err !== 2'b00 || out_coc !== 8'd2 || out_res !== 8'd3) begin
      n_fail++;
      $display("FAIL tie: cyc=%0d err=%0d coc=%0d res=%0d required 65 0 2 3", n + 1, out_err, out_coc, out_res);
    end
    handshake();
    // The answer is one cycle late. The result is a timeout and the late done is ignored.
    dm_lat = 65;
    issue(8'd13, 8'd5);
    wait_out(n);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (out_err !== 2'b10 || out_coc !== 8'd0 || out_res !== 8'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL late_done: err=%0d coc=%0d res=%0d v=%0b required 2 0 0 1", out_err, out_coc, out_res, out_valid);
    end
    handshake();
    dm_lat = 4;
  endtask

  task automatic test_backpressure();
    int n;
    dm_lat = 3;
    issue(8'd9, 8'd4);
    wait_out(n);
    in_valid = 1'b1;
    in_num   = 8'd5;
    in_den   = 8'd1;
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if ({out_valid, out_coc, out_res, out_err, in_ready, div_start, busy} !== {1'b1, 8'd2, 8'd1, 2'b00, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL backpressure c%0d: v=%0b coc=%0d res=%0d err=%0d rdy=%0b start=%0b required 1 2 1 0 0 0",
                 c, out_valid, out_coc, out_res, out_err, in_ready, div_start);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    handshake();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL bp_after: rdy=%0b v=%0b ops=%0d required 1 0 %0d", in_ready, out_valid, ops_cnt, exp_ops);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    dm_lat = 6;
    issue(8'd77, 8'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({in_ready, div_start, div_num, div_den, out_valid, out_coc, out_res, out_err, busy, ops_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait: rdy=%0b start=%0b num=%0d v=%0b busy=%0b ops=%0d required all 0",
               in_ready, div_start, div_num, out_valid, busy, ops_cnt);
    end
    exp_ops = 0;
    // The divider model still answers at cycle 7. The idle driver must ignore that answer.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_late c%0d: v=%0b busy=%0b required 0 0", c, out_valid, busy);
      end
    end
    dm_lat = 2;
    issue(8'd50, 8'd5);
    wait_out(n);
    n_tests++;
    if (out_coc !== 8'd10 || out_res !== 8'd0 || out_err !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_next: coc=%0d res=%0d err=%0d required 10 0 0", out_coc, out_res, out_err);
    end
    handshake();
  endtask

  typedef struct {
    logic [7:0] coc;
    logic [7:0] res;
    logic [1:0] err;
  } result_t;

  task automatic test_back_to_back();
    result_t    q[$];
    result_t    r;
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    logic [7:0] a, b;
    while (got < 300 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected result coc=%0d res=%0d", out_coc, out_res);
        end else begin
          r = q.pop_front();
          if ({out_coc, out_res, out_err} !== {r.coc, r.res, r.err}) begin
            n_fail++;
            $display("FAIL b2b_result #%0d: coc=%0d res=%0d err=%0d required %0d %0d %0d",
                     got, out_coc, out_res, out_err, r.coc, r.res, r.err);
          end
        end
        got++;
        exp_ops++;
      end
      in_valid = 1'b0;
      if (in_ready && sent < 300 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        if (b == 0) begin
          r.coc = 8'hFF; r.res = a; r.err = 2'b01;
        end else begin
          r.coc = a / b; r.res = a % b; r.err = 2'b00;
        end
        q.push_back(r);
        dm_lat   = $urandom_range(1, 10);
        in_num   = a;
        in_den   = b;
        in_valid = 1'b1;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (got !== 300 || ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d ops=%0d required 300 %0d", got, ops_cnt, exp_ops);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_num    = '0;
    in_den    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
